// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice pipeline stages.
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] LVL_MAX = 16'hFFFF;
    localparam int          GAIN_W  = 8;

    // Unsigned 8x8 multiply keeping the top byte of the 16-bit product.
    function automatic logic [7:0] scale_sample(input logic [7:0] s, input logic [7:0] g);
        logic [15:0] p;
        p = {8'd0, s} * {8'd0, g};
        return p[15:8];
    endfunction

endpackage

// File: rtl/env_tick_div.sv
// Free-running divider producing a one-clock pulse every TICK_DIV clocks.
module env_tick_div #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             tick_r;

    // Next count wraps after the last value.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (cnt_r == CNT_LAST) begin
            cnt_nx_s = CNT_ZERO;
        end else begin
            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter and pulse register; the pulse is high while the count sits at its last value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= (CNT_LAST == CNT_ZERO);
        end else begin
            cnt_r  <= cnt_nx_s;
            tick_r <= (cnt_nx_s == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope and amplitude scaler for one voice.
// Optional legato retrigger when ADSR_LEGATO_EN is defined.
module adsr_env
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 1024,
    parameter int LVL_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [7:0]  sample_in,
    input  logic [15:0] attack_step,
    input  logic [15:0] decay_step,
    input  logic [7:0]  sustain_level,
    input  logic [15:0] release_step,
    output logic [7:0]  value,
    output logic        active,
    output logic [2:0]  env_state
);

    localparam int               EW       = LVL_W + 1;
    localparam logic [LVL_W-1:0] LVL_TOP  = {LVL_W{1'b1}};
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

    env_state_t       state_r, state_nx_s;
    logic [LVL_W-1:0] level_r, level_nx_s, target_s;
    logic [EW-1:0]    sum_s, dec_s, rel_s;
    logic             gate_q_r, rise_s, fall_s, tick_s;
    logic [7:0]       value_r;
    logic             active_r;
    logic [2:0]       env_state_r;

    env_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign rise_s   = gate & ~gate_q_r;
    assign fall_s   = ~gate & gate_q_r;
    assign target_s = {sustain_level, {(LVL_W-8){1'b0}}};
    // One extra bit catches attack overflow and decay/release underflow.
    assign sum_s    = {1'b0, level_r} + EW'(attack_step);
    assign dec_s    = {1'b0, level_r} - EW'(decay_step);
    assign rel_s    = {1'b0, level_r} - EW'(release_step);

    // Envelope next state: gate edges override the tick update.
    always_comb begin
        state_nx_s = state_r;
        level_nx_s = level_r;
        if (rise_s) begin
            state_nx_s = ATTACK;
`ifdef ADSR_LEGATO_EN
            if (state_r == IDLE) begin
                level_nx_s = LVL_ZERO;
            end else begin
                level_nx_s = level_r;
            end
`else
            level_nx_s = LVL_ZERO;
`endif
        end else if (fall_s && (state_r inside {ATTACK, DECAY, SUSTAIN})) begin
            state_nx_s = RELEASE;
        end else if (tick_s) begin
            case (state_r)
                IDLE: level_nx_s = LVL_ZERO;
                ATTACK: begin
                    if (sum_s >= {1'b0, LVL_TOP}) begin
                        level_nx_s = LVL_TOP;
                        state_nx_s = DECAY;
                    end else begin
                        level_nx_s = sum_s[LVL_W-1:0];
                    end
                end
                DECAY: begin
                    if (dec_s[LVL_W] || (dec_s[LVL_W-1:0] <= target_s)) begin
                        level_nx_s = target_s;
                        state_nx_s = SUSTAIN;
                    end else begin
                        level_nx_s = dec_s[LVL_W-1:0];
                    end
                end
                SUSTAIN: level_nx_s = target_s;
                RELEASE: begin
                    if (rel_s[LVL_W] || (rel_s[LVL_W-1:0] == LVL_ZERO)) begin
                        level_nx_s = LVL_ZERO;
                        state_nx_s = IDLE;
                    end else begin
                        level_nx_s = rel_s[LVL_W-1:0];
                    end
                end
                default: begin
                    level_nx_s = LVL_ZERO;
                    state_nx_s = IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
            level_nx_s = level_r;
        end
    end

    // State, level, gate history and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            level_r     <= LVL_ZERO;
            gate_q_r    <= 1'b0;
            value_r     <= 8'd0;
            active_r    <= 1'b0;
            env_state_r <= 3'd0;
        end else begin
            state_r     <= state_nx_s;
            level_r     <= level_nx_s;
            gate_q_r    <= gate;
            value_r     <= scale_sample(sample_in, level_r[LVL_W-1 -: GAIN_W]);
            active_r    <= (state_nx_s != IDLE);
            env_state_r <= state_nx_s;
        end
    end

    assign value     = value_r;
    assign active    = active_r;
    assign env_state = env_state_r;

endmodule

// File: tb/tb_adsr_env.sv
// Self-checking bench for adsr_env: directed scenarios plus randomized run against an arithmetic envelope model.
module tb_adsr_env;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset, gate;
    logic [7:0]  sample_in, sustain_level;
    logic [15:0] attack_step, decay_step, release_step;
    logic [7:0]  value;
    logic        active;
    logic [2:0]  env_state;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: integer level, state numbered as in the envelope description.
    int m_state, m_level, m_cnt, m_value;
    bit m_gate_q, m_tick_applied;

    adsr_env #(.TICK_DIV(TD), .LVL_W(16)) dut (
        .clk(clk), .reset(reset), .gate(gate), .sample_in(sample_in),
        .attack_step(attack_step), .decay_step(decay_step),
        .sustain_level(sustain_level), .release_step(release_step),
        .value(value), .active(active), .env_state(env_state)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int  tgt, l;
        bit  tick, rise, fall;
        m_tick_applied = 1'b0;
        if (!reset) begin
            m_state = 0; m_level = 0; m_cnt = 0; m_value = 0; m_gate_q = 1'b0;
            return;
        end
        tick    = (m_cnt == TD - 1);
        m_cnt   = (m_cnt + 1) % TD;
        m_value = (int'(sample_in) * (m_level / 256)) / 256;
        rise    = gate && !m_gate_q;
        fall    = !gate && m_gate_q;
        m_gate_q = gate;
        tgt     = int'(sustain_level) * 256;
        if (rise) begin
`ifdef ADSR_LEGATO_EN
            if (m_state == 0) m_level = 0;
`else
            m_level = 0;
`endif
            m_state = 1;
        end else if (fall && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (tick) begin
            m_tick_applied = 1'b1;
            case (m_state)
                1: begin l = m_level + int'(attack_step);
                         if (l >= 65535) begin m_level = 65535; m_state = 2; end else m_level = l; end
                2: begin l = m_level - int'(decay_step);
                         if (l <= tgt) begin m_level = tgt; m_state = 3; end else m_level = l; end
                3: m_level = tgt;
                4: begin l = m_level - int'(release_step);
                         if (l <= 0) begin m_level = 0; m_state = 0; end else m_level = l; end
                default: m_level = 0;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run_to_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            if (m_tick_applied) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; gate = 1'b1; sample_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_total++; if (value !== 8'd0) $display("FAIL reset_value got %0h want 0", value); else n_pass++;
            n_total++; if (active !== 1'b0) $display("FAIL reset_active got %0b want 0", active); else n_pass++;
            n_total++; if (env_state !== 3'd0) $display("FAIL reset_state got %0d want 0", env_state); else n_pass++;
        end
        reset = 1'b1;
        cyc();
        n_total++; if (env_state !== 3'd1) $display("FAIL reset_first_rise got %0d want 1", env_state); else n_pass++;
        reset = 1'b0; gate = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        n_total++; if (env_state !== 3'd0) $display("FAIL reset_idle_again got %0d want 0", env_state); else n_pass++;
    endtask

    task automatic test_attack();
        bit ok;
        logic [7:0] exp_v [4] = '{8'h3F, 8'h7F, 8'hBF, 8'hFE};
        attack_step = 16'h4000; decay_step = 16'h1000; sustain_level = 8'h80;
        release_step = 16'h2000; sample_in = 8'hFF; gate = 1'b1;
        cyc();
        n_total++; if (env_state !== 3'd1) $display("FAIL attack_enter got %0d want 1", env_state); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            run_to_tick(ok);
            n_total++; if (!ok) $display("FAIL attack_tick_timeout got 0 want 1"); else n_pass++;
            n_total++;
            if (env_state !== ((k == 3) ? 3'd2 : 3'd1))
                $display("FAIL attack_state tick %0d got %0d want %0d", k + 1, env_state, (k == 3) ? 2 : 1);
            else n_pass++;
            cyc();
            n_total++; if (value !== exp_v[k]) $display("FAIL attack_value tick %0d got %0h want %0h", k + 1, value, exp_v[k]); else n_pass++;
        end
    endtask

    task automatic test_decay_sustain();
        bit ok;
        for (int k = 1; k <= 8; k++) begin
            run_to_tick(ok);
            n_total++;
            if (env_state !== ((k == 8) ? 3'd3 : 3'd2))
                $display("FAIL decay_state tick %0d got %0d want %0d ok=%0b", k, env_state, (k == 8) ? 3 : 2, ok);
            else n_pass++;
        end
        sample_in = 8'hC8;
        cyc();
        n_total++; if (value !== 8'h64) $display("FAIL sustain_value got %0h want 64", value); else n_pass++;
    endtask

    task automatic test_release();
        bit ok;
        logic [7:0] exp_v [4] = '{8'd75, 8'd50, 8'd25, 8'd0};
        gate = 1'b0;
        cyc();
        n_total++; if (env_state !== 3'd4) $display("FAIL release_enter got %0d want 4", env_state); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            run_to_tick(ok);
            n_total++;
            if (env_state !== ((k == 3) ? 3'd0 : 3'd4))
                $display("FAIL release_state tick %0d got %0d ok=%0b", k + 1, env_state, ok);
            else n_pass++;
            cyc();
            n_total++; if (value !== exp_v[k]) $display("FAIL release_value tick %0d got %0d want %0d", k + 1, value, exp_v[k]); else n_pass++;
        end
        n_total++; if (active !== 1'b0) $display("FAIL release_active got %0b want 0", active); else n_pass++;
    endtask

    task automatic test_retrigger();
        bit ok;
        logic [7:0] want;
        sample_in = 8'hFF; gate = 1'b1;
        cyc();
        for (int i = 0; i < 40; i++) begin
            run_to_tick(ok);
            if (env_state == 3'd3) break;
        end
        n_total++; if (env_state !== 3'd3) $display("FAIL retrig_reach_sustain got %0d want 3", env_state); else n_pass++;
        gate = 1'b0;
        cyc();
        run_to_tick(ok); run_to_tick(ok);
        n_total++; if (env_state !== 3'd4) $display("FAIL retrig_in_release got %0d want 4", env_state); else n_pass++;
        gate = 1'b1;
        cyc();
        n_total++; if (env_state !== 3'd1) $display("FAIL retrig_state got %0d want 1", env_state); else n_pass++;
        cyc();
`ifdef ADSR_LEGATO_EN
        want = 8'h3F;
`else
        want = 8'h00;
`endif
        n_total++; if (value !== want) $display("FAIL retrig_level got %0h want %0h", value, want); else n_pass++;
    endtask

    task automatic test_collision();
        bit ok;
        for (int i = 0; i < 20; i++) begin
            run_to_tick(ok);
            if (env_state == 3'd2) break;
        end
        run_to_tick(ok);
        n_total++; if (env_state !== 3'd2) $display("FAIL collide_in_decay got %0d want 2", env_state); else n_pass++;
        for (int i = 0; i < TD && m_cnt != TD - 1; i++) cyc();
        gate = 1'b0; sample_in = 8'hFF;
        cyc();
        n_total++; if (env_state !== 3'd4) $display("FAIL collide_state got %0d want 4", env_state); else n_pass++;
        cyc();
        n_total++; if (value !== 8'hEE) $display("FAIL collide_level got %0h want ee", value); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom % 150 != 0);
            if ($urandom % 20 == 0) gate = ~gate;
            sample_in = 8'($urandom);
            if ($urandom % 40 == 0) begin
                attack_step   = ($urandom % 8 == 0) ? 16'h0000 : (($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom_range(1, 16'h6000)));
                decay_step    = ($urandom % 8 == 0) ? 16'h0000 : (($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom_range(1, 16'h3000)));
                release_step  = ($urandom % 8 == 0) ? 16'h0000 : (($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom_range(1, 16'h3000)));
                sustain_level = 8'($urandom);
            end
            cyc();
            n_total++; if (value !== 8'(m_value)) $display("FAIL rand_value cyc %0d got %0d want %0d", i, value, m_value); else n_pass++;
            n_total++; if (env_state !== 3'(m_state)) $display("FAIL rand_state cyc %0d got %0d want %0d", i, env_state, m_state); else n_pass++;
            n_total++; if (active !== (m_state != 0)) $display("FAIL rand_active cyc %0d got %0b want %0b", i, active, m_state != 0); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; gate = 1'b0; sample_in = 8'd0; sustain_level = 8'd0;
        attack_step = 16'd0; decay_step = 16'd0; release_step = 16'd0;
        m_state = 0; m_level = 0; m_cnt = 0; m_value = 0; m_gate_q = 1'b0; m_tick_applied = 1'b0;
        @(negedge clk);
        test_reset();
        test_attack();
        test_decay_sustain();
        test_release();
        test_retrigger();
        test_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
- Envelope generator and amplitude scaler placed directly downstream of the noise/oscillator source.
- Consumes the source's unsigned 8-bit `value` sample and a note gate.
- Runs an attack/decay/sustain/release state machine on a 16-bit level.
- Outputs the sample scaled by the level's upper byte, as the voice output to the mixer/DAC stage.

Parameters:
- TICK_DIV, 1024: clocks per envelope update tick. Must be ≥ 1. 1 = update every clock.
- LVL_W, 16: envelope level register width. Gain is `level[LVL_W-1:LVL_W-8]`.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- gate  in  1  note on (1) / off (0). Level-sensitive, internally edge-detected.
- sample_in  in  8  unsigned sample from upstream generator.
- attack_step  in  16  level increment per tick in ATTACK.
- decay_step  in  16  level decrement per tick in DECAY.
- sustain_level  in  8  sustain gain; target level = `{sustain_level, 8'h00}`.
- release_step  in  16  level decrement per tick in RELEASE.
- value  out  8  scaled output sample.
- active  out  1  high when state != IDLE.
- env_state  out  3  current state encoding.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, level=0, `value`=0, `active`=0, tick counter=0, `gate_q`=0. Reset asserted mid-note aborts immediately; no release phase.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - Tick pulse is asserted in the cycle where counter==TICK_DIV-1.
  - Counter free-runs regardless of state.
  - Level changes only on tick, except on gate edges.
- Gate edges: `gate_q` registers `gate`.
  - rise = gate & ~gate_q.
  - fall = ~gate & gate_q.
  - Edge handling takes priority over the tick update in the same cycle.
- States and transitions:
  - IDLE (0):
    - level held at 0.
    - rise: level<=0, go to ATTACK.
  - ATTACK (1):
    - On tick: level += attack_step, saturating.
    - If sum ≥ 0xFFFF: level<=0xFFFF, go to DECAY.
  - DECAY (2):
    - On tick: level -= decay_step.
    - If result ≤ sustain target or underflows: level<=target, go to SUSTAIN.
    - If entered with level already ≤ target: first tick clamps to target, go to SUSTAIN.
  - SUSTAIN (3):
    - On each tick: level<=target, so live sustain_level changes track at tick rate.
  - RELEASE (4):
    - On tick: level -= release_step.
    - If result ≤ 0 or underflows: level<=0, go to IDLE.
- Gate events by state:
  - fall in ATTACK, DECAY or SUSTAIN: go to RELEASE next cycle; level unchanged in that cycle.
  - rise in any non-IDLE state: retrigger per the Optional Feature.
- Zero steps:
  - attack_step=0 stalls in ATTACK.
  - decay_step=0 stalls in DECAY.
  - release_step=0 stalls in RELEASE.
  - No timeout in any of these cases.
- Output:
  - `value` <= `(sample_in * level[15:8]) >> 8`, full 16-bit product, top byte kept.
  - Registered every clock; 1-cycle latency from `sample_in` and from level.
  - Gain 0xFF yields at most 254. Gain 0 yields 0.
- `active` and `env_state` are registered with state; no extra latency.

Optional Feature:
- Macro ADSR_LEGATO_EN.
  - Defined: rise while not IDLE enters ATTACK with level kept, so attack resumes from the current level.
  - Undefined: any rise forces level<=0 and enters ATTACK (hard retrigger).
- Behaviour from IDLE is identical in both builds.

Decomposition:
- Package `synth_pkg`:
  - `env_state_t` enum, 3 bits: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
  - Constants LVL_MAX=16'hFFFF and GAIN_W=8.
- Sub-module `env_tick_div`:
  - Parameter TICK_DIV.
  - Ports clk, reset, tick.
  - Single-cycle pulse generator; reusable by other timed synth stages.

Test Plan:
- Reset:
  - Stimulus: reset=0 for 3 clocks with gate=1, sample_in=0xFF.
  - Required: `value`=0, `active`=0, `env_state`=0 throughout. `env_state` stays IDLE until the first posedge where reset==1 and rise is seen.
- Attack:
  - Stimulus: TICK_DIV=4, attack_step=0x4000, gate rises.
  - Required: level 0x4000, 0x8000, 0xC000, then 0xFFFF on ticks 1–4; DECAY entered after the 4th tick.
- Decay/sustain:
  - Stimulus: decay_step=0x1000, sustain_level=0x80.
  - Required: on the 8th decay tick level clamps to 0x8000 and state=SUSTAIN. With sample_in=0xC8, `value`=0x64 one clock later.
- Release:
  - Stimulus: gate falls in SUSTAIN, release_step=0x2000.
  - Required: RELEASE the next cycle. Level steps down 0x2000 per tick and reaches 0 on the 4th tick. State=IDLE, `active`=0, `value`=0.
- Retrigger:
  - Stimulus: rise during RELEASE at level 0x4000.
  - Required without ADSR_LEGATO_EN: level=0, ATTACK.
  - Required with ADSR_LEGATO_EN: level stays 0x4000, ATTACK.
- Edge/tick collision:
  - Stimulus: gate fall lands in the same cycle as a tick in DECAY.
  - Required: RELEASE entered, level not decremented that cycle.
